inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch unit feeding the control decoder (`ctrl`) of the rysyCore pipeline. Holds the program counter and issues word reads to instruction memory over a req/ack handshake. Buffers returned words in a small FIFO and presents the head instruction, pre-split into opcode/func3/func7/register fields, to the decoder through a valid/ready handshake. Accepts redirects (branch/jump targets) from the execute side, flushing stale instructions.

## Interface
Parameters:
- `DEPTH`, 2: instruction buffer entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: fetch address after reset; word aligned.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `mem_req`  out  1  read request to instruction memory.
- `mem_addr`  out  32  word address of the request; bits [1:0] always 0.
- `mem_ack`  in  1  memory returns `mem_rdata` this cycle.
- `mem_rdata`  in  32  instruction word; valid only when `mem_ack`=1.
- `redirect`  in  1  one-cycle pulse: restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored (treated as 0).
- `inst_valid`  out  1  buffer head holds a valid instruction.
- `inst_ready`  in  1  decoder accepts the head this cycle.
- `inst`  out  32  head instruction word.
- `inst_pc`  out  32  address the head instruction was fetched from.
- `opcode`  out  7  `inst[6:0]`.
- `rd`  out  5  `inst[11:7]`.
- `func3`  out  3  `inst[14:12]`.
- `rs1`  out  5  `inst[19:15]`.
- `rs2`  out  5  `inst[24:20]`.
- `func7`  out  7  `inst[31:25]`.

## Operation
- Reset (asynchronous, immediate): fetch PC = `RESET_PC`, buffer empty, `mem_req`=0, `mem_addr`=`RESET_PC`, `inst_valid`=0, `inst`/`inst_pc` and all field outputs 0, drop flag clear.
- State: fetch PC, `mem_req`/`mem_addr` registers, DEPTH-entry FIFO of {word, pc}, count, one-bit `drop` flag.
- Memory protocol: at most one outstanding request. Once `mem_req`=1, `mem_req` and `mem_addr` hold stable until a cycle with `mem_ack`=1. `mem_ack` with `mem_req`=0 is ignored.
- Issue rule: a request is raised/kept when count + (outstanding after this edge) < DEPTH+1, i.e. a returned word always has a free slot. The FIFO never overflows.
- On an accepted ack: if `drop`=0, push {`mem_rdata`, `mem_addr`}, fetch PC += 4 (32-bit wrap: 0xFFFF_FFFC → 0); if space remains, next request (new address) is asserted the following cycle without a gap.
- Dequeue: `inst_valid`=1 whenever count>0; outputs are driven combinationally from the FIFO head. Head pops on `inst_valid && inst_ready`. Push and pop in the same cycle are both performed.
- Redirect (priority over push and pop): FIFO cleared, fetch PC = `{redirect_pc[31:2],2'b00}`. If a request is outstanding and not acked in this cycle, it completes normally but its data is discarded (`drop`=1 until that ack). An ack arriving in the redirect cycle is discarded. The first new request is to the redirect address.
- Redirect while `drop`=1: only the PC is updated; `drop` stays set.

## Timing
- Ack in cycle N → `inst_valid`=1 in cycle N+1 (1-cycle latency).
- After reset release: `mem_req`=1 at the first rising edge.
- Zero-wait memory (ack in the first request cycle): sustained 1 instruction/cycle with `inst_ready`=1.
- Redirect in cycle N: `inst_valid`=0 in N+1. With no outstanding request, `mem_req`=1 with `mem_addr`=target in N+1.
- Ready stalled: fetch stops once DEPTH words are buffered. `mem_req` stays 0 until a pop frees a slot, then rises the next cycle.

## Test plan
- Reset mid-fetch (`mem_req`=1, 1 entry buffered): assert `rst` → immediately `mem_req`=0, `inst_valid`=0, fields 0; release → first request to `RESET_PC`=0x0.
- Zero-wait memory returning 0x00500093, 0x40208133 at 0x0, 0x4, `inst_ready`=1 → heads in consecutive cycles. Second head: `opcode`=0x33, `func3`=0, `func7`=0x20, `rs1`=1, `rs2`=2, `rd`=2, `inst_pc`=0x4.
- `inst_ready`=0 for 10 cycles → exactly DEPTH=2 words buffered, `mem_req`=0. One pop → one new request at 0x8.
- Redirect to 0x103 while a 3-wait-state request to 0x8 is outstanding → 0x8 data discarded, next `mem_addr`=0x100, next head `inst_pc`=0x100.
- Redirect coincident with ack and a pop → acked word dropped, FIFO empty next cycle, request to target.
- PC wrap: redirect to 0xFFFF_FFFC, two fetches → `mem_addr` sequence 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack port, redirect input and
// the decoded head-of-buffer valid/ready port towards the control decoder.
interface inst_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  func7;

    modport master (
        output mem_req, mem_addr, inst_valid, inst, inst_pc,
               opcode, rd, func3, rs1, rs2, func7,
        input  mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst, inst_pc,
               opcode, rd, func3, rs1, rs2, func7,
        output mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC, single-outstanding memory request, DEPTH-entry
// {word, pc} buffer and redirect handling with discard of in-flight data.
module inst_fetch #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_q, req_d;
    logic          drop_q, drop_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   word_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic          ack_acc, push, pop, valid;
    logic [31:0]   head_word, head_pc;

    always_comb begin
        ack_acc = req_q && bus.mem_ack;
        valid   = (count_q != '0);
        push    = ack_acc && !drop_q && !bus.redirect;
        pop     = valid && bus.inst_ready && !bus.redirect;
        pc_d    = pc_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        drop_d  = drop_q;
        if (bus.redirect) begin
            pc_d    = {bus.redirect_pc[31:2], 2'b00};
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
            // a request still in flight after this edge returns stale data
            drop_d  = req_q && !bus.mem_ack;
        end else begin
            drop_d = drop_q && !ack_acc;
            if (push) begin
                pc_d   = pc_q + 32'd4;
                wptr_d = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
        // an unacked request is held; otherwise issue only if its word has a slot
        if (req_q && !bus.mem_ack) begin
            req_d  = 1'b1;
            addr_d = addr_q;
        end else begin
            req_d  = (count_d < CW'(DEPTH));
            addr_d = pc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            drop_q  <= drop_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wptr_q] <= bus.mem_rdata;
            pc_mem[wptr_q]   <= addr_q;
        end
    end

    // outputs read zero while the buffer is empty
    assign head_word = valid ? word_mem[rptr_q] : '0;
    assign head_pc   = valid ? pc_mem[rptr_q]   : '0;

    assign bus.mem_req    = req_q;
    assign bus.mem_addr   = addr_q;
    assign bus.inst_valid = valid;
    assign bus.inst       = head_word;
    assign bus.inst_pc    = head_pc;
    assign bus.opcode     = head_word[6:0];
    assign bus.rd         = head_word[11:7];
    assign bus.func3      = head_word[14:12];
    assign bus.rs1        = head_word[19:15];
    assign bus.rs2        = head_word[24:20];
    assign bus.func7      = head_word[31:25];
endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a memory responder with random wait states
// predicts the delivered instruction stream; a monitor checks every head popped.
module tb_inst_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    inst_fetch_if bus ();

    inst_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    ent_t        sb[$];
    logic [31:0] req_log[$];
    logic [31:0] exp_pc = RESET_PC;
    logic        stale = 1'b0;
    logic        outstanding = 1'b0;
    logic [31:0] held_addr = '0;
    int          wait_left = 0;
    int          force_wait = 0;
    int          max_wait = 3;
    logic        pushed_now = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h4020_8133;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    // memory responder + stream model; called once per cycle after sync()
    task automatic drive(input logic rdy, input logic redir, input logic [31:0] rpc);
        logic ack;
        ack = 1'b0;
        if (outstanding) chk("req_held", bus.mem_req, 1'b1);
        if (bus.mem_req) begin
            if (!outstanding) begin
                outstanding = 1'b1;
                held_addr   = bus.mem_addr;
                req_log.push_back(bus.mem_addr);
                chk("req_addr", bus.mem_addr, exp_pc);
                wait_left = (force_wait >= 0) ? force_wait : int'($urandom_range(0, max_wait));
            end else begin
                chk("req_stable", bus.mem_addr, held_addr);
            end
            if (wait_left == 0) begin
                ack         = 1'b1;
                outstanding = 1'b0;
            end else begin
                wait_left--;
            end
        end
        pushed_now = 1'b0;
        if (redir) begin
            sb.delete();
            stale  = bus.mem_req && !ack;
            exp_pc = {rpc[31:2], 2'b00};
        end else if (ack) begin
            if (stale) begin
                stale = 1'b0;
            end else begin
                sb.push_back('{pc: exp_pc, word: memf(exp_pc)});
                exp_pc     = exp_pc + 32'd4;
                pushed_now = 1'b1;
            end
        end
        bus.mem_ack     = ack;
        bus.mem_rdata   = ack ? memf(bus.mem_addr) : $urandom;
        bus.inst_ready  = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
    endtask

    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
        sync();
        drive(rdy, redir, rpc);
    endtask

    task automatic do_reset(input logic rdy);
        sync();
        rst             = 1'b1;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        sb.delete();
        req_log.delete();
        outstanding = 1'b0;
        stale       = 1'b0;
        exp_pc      = RESET_PC;
        pushed_now  = 1'b0;
        #1;
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, RESET_PC);
        chk("rst_valid", bus.inst_valid, 1'b0);
        chk("rst_inst", {bus.inst_pc, bus.inst}, 64'h0);
        chk("rst_fields", {bus.func7, bus.rs2, bus.rs1, bus.func3, bus.rd, bus.opcode}, 32'h0);
        sync();
        rst = 1'b0;
        sync();
        chk("first_req", bus.mem_req, 1'b1);
        drive(rdy, 1'b0, '0);
    endtask

    // monitor: pops the scoreboard whenever the decoder consumes a head
    initial begin
        int   n;
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !bus.redirect) begin
                n = sb.size() - (pushed_now ? 1 : 0);
                chk("valid", bus.inst_valid, (n > 0));
                if (bus.inst_valid && bus.inst_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_nonempty", 0, 1);
                    end else begin
                        e = sb.pop_front();
                        chk("head_pc", bus.inst_pc, e.pc);
                        chk("head_inst", bus.inst, e.word);
                        chk("fields", {bus.func7, bus.rs2, bus.rs1, bus.func3, bus.rd, bus.opcode}, e.word);
                    end
                end
            end
        end
    end

    initial begin
        logic found;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.inst_ready = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = '0;

        // stalled decoder: buffer fills to DEPTH, then one pop frees a slot
        force_wait = 0;
        do_reset(1'b0);
        repeat (10) step(1'b0, 1'b0, '0);
        chk("stall_req", bus.mem_req, 1'b0);
        chk("stall_count", sb.size(), DEPTH);
        chk("stall_valid", bus.inst_valid, 1'b1);
        chk("stall_head", bus.inst_pc, 32'h0);
        step(1'b1, 1'b0, '0);
        sync();
        chk("refill_req", bus.mem_req, 1'b1);
        chk("refill_addr", bus.mem_addr, 32'h8);
        drive(1'b0, 1'b0, '0);
        repeat (3) step(1'b1, 1'b0, '0);

        // reset mid-fetch, then zero-wait back-to-back delivery
        do_reset(1'b1);
        step(1'b1, 1'b0, '0);
        #1;
        chk("zw_head0", bus.inst_pc, 32'h0);
        step(1'b1, 1'b0, '0);
        #1;
        chk("zw_head1_pc", bus.inst_pc, 32'h4);
        chk("zw_inst", bus.inst, 32'h4020_8133);
        chk("zw_opcode", bus.opcode, 7'h33);
        chk("zw_func3", bus.func3, 3'h0);
        chk("zw_func7", bus.func7, 7'h20);
        chk("zw_rs1", bus.rs1, 5'd1);
        chk("zw_rs2", bus.rs2, 5'd2);
        chk("zw_rd", bus.rd, 5'd2);

        // redirect while a 3-wait request to 0x8 is in flight
        force_wait = 3;
        do_reset(1'b1);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            sync();
            if (bus.mem_req && !outstanding && bus.mem_addr == 32'h8) begin
                drive(1'b1, 1'b1, 32'h103);
                found = 1'b1;
                break;
            end
            drive(1'b1, 1'b0, '0);
        end
        chk("redir_found", found, 1'b1);
        req_log.delete();
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            sync();
            if (bus.inst_valid) begin
                found = 1'b1;
                break;
            end
            drive(1'b0, 1'b0, '0);
        end
        chk("redir_valid_seen", found, 1'b1);
        chk("redir_head_pc", bus.inst_pc, 32'h100);
        chk("redir_first_req", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, 32'h100);
        drive(1'b1, 1'b0, '0);

        // redirect coincident with ack and pop
        force_wait = 0;
        repeat (4) step(1'b1, 1'b0, '0);
        sync();
        chk("coin_pre_valid", bus.inst_valid, 1'b1);
        chk("coin_pre_req", bus.mem_req, 1'b1);
        drive(1'b1, 1'b1, 32'h200);
        sync();
        chk("coin_valid", bus.inst_valid, 1'b0);
        chk("coin_req", bus.mem_req, 1'b1);
        chk("coin_addr", bus.mem_addr, 32'h200);
        drive(1'b1, 1'b0, '0);
        repeat (3) step(1'b1, 1'b0, '0);

        // address wrap at the top of memory
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        req_log.delete();
        repeat (4) step(1'b1, 1'b0, '0);
        chk("wrap_a0", (req_log.size() > 1) ? req_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        chk("wrap_a1", (req_log.size() > 1) ? req_log[1] : 32'hDEAD_BEEF, 32'h0);

        // random traffic
        force_wait = -1;
        max_wait   = 3;
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, rpc);
        end
        repeat (3) step(1'b1, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
